// File: rtl/forward_scoreboard_pkg.sv
// Shared types and helpers for the operand-forwarding scoreboard.
// The data word is kept outside the tag struct so the tag type stays
// independent of the data-width parameter.
package forward_scoreboard_pkg;

  // Architectural zero register: never a forwarding source or destination.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Per-entry bookkeeping for one in-flight write (data lives alongside).
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       ready;
  } fwd_tag_t;

  // Saturating 32-bit increment used by the stall counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

  // True when an entry is a live write to the (non-zero) source register.
  function automatic logic tag_hit(input fwd_tag_t t, input logic [4:0] rs);
    return (rs != REG_ZERO) && t.valid && (t.rd == rs);
  endfunction

endpackage

// File: rtl/forward_scoreboard_if.sv
// Bus between the core's ID/EX stage and the forwarding scoreboard.
// master = core side (drives pipeline control and operand requests),
// slave  = scoreboard side (returns forwarded operands and the stall).
interface forward_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREAD = 2
);
  logic                    adv;
  logic                    flush;
  logic                    ins_valid;
  logic [4:0]              ins_rd;
  logic [XLEN-1:0]         ins_data;
  logic                    ins_load;
  logic                    ld_valid;
  logic [XLEN-1:0]         ld_data;
  logic [NREAD*5-1:0]      rs;
  logic [NREAD*XLEN-1:0]   rf_data;
  logic [NREAD*XLEN-1:0]   op_data;
  logic                    stall;
  logic [31:0]             stall_cnt;

  modport master (
    output adv, flush, ins_valid, ins_rd, ins_data, ins_load,
    output ld_valid, ld_data, rs, rf_data,
    input  op_data, stall, stall_cnt
  );

  modport slave (
    input  adv, flush, ins_valid, ins_rd, ins_data, ins_load,
    input  ld_valid, ld_data, rs, rf_data,
    output op_data, stall, stall_cnt
  );
endinterface

// File: rtl/forward_scoreboard_port_sel.sv
// One source-operand port: picks the youngest live write to rs and either
// forwards its data or, if that write is a load still waiting for memory,
// falls back to the register file and flags a hazard. An older ready value
// must never hide a younger pending load, so the search stops at the first hit.
module forward_scoreboard_port_sel
  import forward_scoreboard_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 3
) (
  input  logic [4:0]                  rs_i,
  input  logic [XLEN-1:0]             rf_data_i,
  input  fwd_tag_t [DEPTH-1:0]        tag_i,
  input  logic [DEPTH-1:0][XLEN-1:0]  data_i,
  output logic [XLEN-1:0]             op_data_o,
  output logic                        hazard_o
);

  logic found_s;

  // Youngest-first priority search plus operand mux.
  always_comb begin
    op_data_o = rf_data_i;
    hazard_o  = 1'b0;
    found_s   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found_s && tag_hit(tag_i[i], rs_i)) begin
        found_s = 1'b1;
        if (tag_i[i].ready) begin
          op_data_o = data_i[i];
          hazard_o  = 1'b0;
        end else begin
          op_data_o = rf_data_i;
          hazard_o  = 1'b1;
        end
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Operand-forwarding scoreboard: a shadow pipeline of DEPTH in-flight writes
// (entry 0 youngest) feeding NREAD forwarding ports. Handles insertion on
// advance, load-data fill at LD_STAGE, partial flush of the youngest FLUSH_N
// entries, and a saturating count of stalled cycles.
module forward_scoreboard
  import forward_scoreboard_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 3,
  parameter int NREAD    = 2,
  parameter int LD_STAGE = 1,
  parameter int FLUSH_N  = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  forward_scoreboard_if.slave   fwd_bus
);

  fwd_tag_t [DEPTH-1:0]              tag_q;
  fwd_tag_t [DEPTH-1:0]              tag_d;
  logic     [DEPTH-1:0][XLEN-1:0]    data_q;
  logic     [DEPTH-1:0][XLEN-1:0]    data_d;
  logic     [31:0]                   cnt_q;
  logic     [31:0]                   cnt_d;
  logic     [NREAD-1:0]              hazard_s;
  logic     [NREAD-1:0][XLEN-1:0]    op_s;
  logic                              stall_s;
  logic                              fill_s;

  // A returning load only lands on a live entry that is still waiting.
  assign fill_s = fwd_bus.ld_valid & tag_q[LD_STAGE].valid & ~tag_q[LD_STAGE].ready;

  // Next state: fill first, then flush, then shift, so a filled value rides
  // the shift and flushed slots move on as bubbles.
  always_comb begin
    tag_d  = tag_q;
    data_d = data_q;

    if (fill_s) begin
      tag_d[LD_STAGE].ready = 1'b1;
      data_d[LD_STAGE]      = fwd_bus.ld_data;
    end else begin
      tag_d[LD_STAGE].ready = tag_q[LD_STAGE].ready;
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (fwd_bus.flush && (i < FLUSH_N)) begin
        tag_d[i].valid = 1'b0;
      end else begin
        tag_d[i].valid = tag_d[i].valid;
      end
    end

    if (fwd_bus.adv) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        tag_d[i]  = tag_d[i-1];
        data_d[i] = data_d[i-1];
      end
      tag_d[0].valid = fwd_bus.ins_valid & ~fwd_bus.flush & (fwd_bus.ins_rd != REG_ZERO);
      tag_d[0].rd    = fwd_bus.ins_rd;
      tag_d[0].ready = ~fwd_bus.ins_load;
      data_d[0]      = fwd_bus.ins_data;
    end else begin
      tag_d[0]  = tag_d[0];
      data_d[0] = data_d[0];
    end
  end

  // Count every edge that sees a stall, sticking at all-ones.
  always_comb begin
    if (stall_s) begin
      cnt_d = sat_inc32(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Shadow-pipeline and stall-counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q  <= '0;
      data_q <= '0;
      cnt_q  <= 32'd0;
    end else begin
      tag_q  <= tag_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    forward_scoreboard_port_sel #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
    ) u_sel (
      .rs_i      (fwd_bus.rs[5*p +: 5]),
      .rf_data_i (fwd_bus.rf_data[XLEN*p +: XLEN]),
      .tag_i     (tag_q),
      .data_i    (data_q),
      .op_data_o (op_s[p]),
      .hazard_o  (hazard_s[p])
    );
  end

  assign stall_s           = |hazard_s;
  assign fwd_bus.op_data   = op_s;
  assign fwd_bus.stall     = stall_s;
  assign fwd_bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard. Two instances share one stimulus:
// dut_a fills loads at entry 0, dut_b at entry 1. A behavioural model of each
// is checked every negative edge; literal expectations pin key points.
module tb_forward_scoreboard;
  localparam int XLEN    = 32;
  localparam int DEPTH   = 3;
  localparam int NREAD   = 2;
  localparam int FLUSH_N = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        adv = 1'b0, flush = 1'b0, ins_valid = 1'b0, ins_load = 1'b0, ld_valid = 1'b0;
  logic [4:0]  ins_rd = 5'd0, rs0 = 5'd0, rs1 = 5'd0;
  logic [31:0] ins_data = 32'd0, ld_data = 32'd0;
  logic [31:0] rf0 = 32'hA0A0_0000, rf1 = 32'hB1B1_1111;

  int n_chk = 0;
  int n_fail = 0;

  forward_scoreboard_if #(.XLEN(XLEN), .NREAD(NREAD)) bus_a ();
  forward_scoreboard_if #(.XLEN(XLEN), .NREAD(NREAD)) bus_b ();

  assign bus_a.adv = adv;           assign bus_b.adv = adv;
  assign bus_a.flush = flush;       assign bus_b.flush = flush;
  assign bus_a.ins_valid = ins_valid; assign bus_b.ins_valid = ins_valid;
  assign bus_a.ins_rd = ins_rd;     assign bus_b.ins_rd = ins_rd;
  assign bus_a.ins_data = ins_data; assign bus_b.ins_data = ins_data;
  assign bus_a.ins_load = ins_load; assign bus_b.ins_load = ins_load;
  assign bus_a.ld_valid = ld_valid; assign bus_b.ld_valid = ld_valid;
  assign bus_a.ld_data = ld_data;   assign bus_b.ld_data = ld_data;
  assign bus_a.rs = {rs1, rs0};     assign bus_b.rs = {rs1, rs0};
  assign bus_a.rf_data = {rf1, rf0}; assign bus_b.rf_data = {rf1, rf0};

  forward_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD), .LD_STAGE(0), .FLUSH_N(FLUSH_N))
    dut_a (.clk(clk), .rst_n(rst_n), .fwd_bus(bus_a));
  forward_scoreboard #(.XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD), .LD_STAGE(1), .FLUSH_N(FLUSH_N))
    dut_b (.clk(clk), .rst_n(rst_n), .fwd_bus(bus_b));

  // ---------------- behavioural model ----------------
  typedef struct {
    bit        v;
    bit [4:0]  rd;
    bit [31:0] d;
    bit        rdy;
  } ent_t;

  ent_t        m [2][DEPTH];
  logic [31:0] m_cnt [2];
  int          ls [2] = '{0, 1};

  // First (youngest) entry writing rs decides; x0 and misses read the RF.
  function automatic logic [31:0] exp_op(int d, logic [4:0] rs, logic [31:0] rf);
    for (int i = 0; i < DEPTH; i++)
      if (rs != 5'd0 && m[d][i].v && m[d][i].rd == rs)
        return m[d][i].rdy ? m[d][i].d : rf;
    return rf;
  endfunction

  function automatic logic exp_haz(int d, logic [4:0] rs);
    for (int i = 0; i < DEPTH; i++)
      if (rs != 5'd0 && m[d][i].v && m[d][i].rd == rs)
        return !m[d][i].rdy;
    return 1'b0;
  endfunction

  function automatic logic exp_stall(int d);
    return exp_haz(d, rs0) | exp_haz(d, rs1);
  endfunction

  task automatic model_edge(int d);
    ent_t e [DEPTH];
    if (exp_stall(d) && m_cnt[d] != 32'hFFFF_FFFF) m_cnt[d] = m_cnt[d] + 32'd1;
    for (int i = 0; i < DEPTH; i++) e[i] = m[d][i];
    if (ld_valid && e[ls[d]].v && !e[ls[d]].rdy) begin
      e[ls[d]].d = ld_data;
      e[ls[d]].rdy = 1'b1;
    end
    if (flush) for (int i = 0; i < FLUSH_N; i++) e[i].v = 1'b0;
    if (adv) begin
      for (int i = DEPTH - 1; i > 0; i--) e[i] = e[i-1];
      e[0].v = ins_valid && !flush && (ins_rd != 5'd0);
      e[0].rd = ins_rd;
      e[0].d = ins_data;
      e[0].rdy = !ins_load;
    end
    for (int i = 0; i < DEPTH; i++) m[d][i] = e[i];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_cnt[d] = 32'd0;
        for (int i = 0; i < DEPTH; i++) m[d][i] = '{1'b0, 5'd0, 32'd0, 1'b0};
      end
    end else begin
      model_edge(0);
      model_edge(1);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(int d, logic [63:0] op, logic st, logic [31:0] cnt);
    chk(d == 0 ? "a.op0" : "b.op0", op[31:0],  exp_op(d, rs0, rf0));
    chk(d == 0 ? "a.op1" : "b.op1", op[63:32], exp_op(d, rs1, rf1));
    chk(d == 0 ? "a.stall" : "b.stall", {31'd0, st}, {31'd0, exp_stall(d)});
    chk(d == 0 ? "a.cnt" : "b.cnt", cnt, m_cnt[d]);
  endtask

  always @(negedge clk) begin
    cmp_dut(0, bus_a.op_data, bus_a.stall, bus_a.stall_cnt);
    cmp_dut(1, bus_b.op_data, bus_b.stall, bus_b.stall_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) tick();
    #2;
    chk("rst a.op0", bus_a.op_data[31:0], 32'hA0A0_0000);
    chk("rst b.op1", bus_b.op_data[63:32], 32'hB1B1_1111);
    chk("rst a.cnt", bus_a.stall_cnt, 32'd0);
    rst_n = 1'b1;
    tick();

    // Youngest of two writes to x5 wins until it retires.
    adv = 1'b1; ins_valid = 1'b1; ins_rd = 5'd5; ins_data = 32'h11;
    tick();
    ins_data = 32'h22;
    tick();
    adv = 1'b0; ins_valid = 1'b0; rs0 = 5'd5; rs1 = 5'd5;
    #2;
    chk("young a.op0", bus_a.op_data[31:0], 32'h22);
    chk("young b.op1", bus_b.op_data[63:32], 32'h22);
    adv = 1'b1;
    tick(); #2;
    chk("bub1 a.op0", bus_a.op_data[31:0], 32'h22);
    tick(); #2;
    chk("bub2 b.op0", bus_b.op_data[31:0], 32'h22);
    tick();
    adv = 1'b0; #2;
    chk("retired a.op0", bus_a.op_data[31:0], 32'hA0A0_0000);

    // Load-use hazard on port 1.
    rs0 = 5'd0; rs1 = 5'd7;
    adv = 1'b1; ins_valid = 1'b1; ins_rd = 5'd7; ins_load = 1'b1; ins_data = 32'h999;
    tick();
    adv = 1'b0; ins_valid = 1'b0; ins_load = 1'b0;
    #2;
    chk("ld a.stall", {31'd0, bus_a.stall}, 32'd1);
    chk("ld a.op1", bus_a.op_data[63:32], 32'hB1B1_1111);
    tick();
    ld_valid = 1'b1; ld_data = 32'hDEAD;
    tick();
    ld_valid = 1'b0; #2;
    chk("fill a.stall", {31'd0, bus_a.stall}, 32'd0);
    chk("fill a.op1", bus_a.op_data[63:32], 32'hDEAD);
    chk("fill a.cnt", bus_a.stall_cnt, 32'd2);
    chk("nofill b.stall", {31'd0, bus_b.stall}, 32'd1);

    // Fill and advance on the same edge at LD_STAGE=1 (dut_b).
    adv = 1'b1;
    tick(); #2;
    chk("b pend e1", {31'd0, bus_b.stall}, 32'd1);
    ld_valid = 1'b1; ld_data = 32'hBEEF;
    tick();
    adv = 1'b0; ld_valid = 1'b0; #2;
    chk("fadv b.op1", bus_b.op_data[63:32], 32'hBEEF);
    chk("fadv b.stall", {31'd0, bus_b.stall}, 32'd0);
    chk("fadv b.cnt", bus_b.stall_cnt, 32'd4);
    chk("fadv a.op1", bus_a.op_data[63:32], 32'hDEAD);

    // x0 destination and x0 source both bypass forwarding.
    rf0 = 32'h1234_5678; rs0 = 5'd0; rs1 = 5'd0;
    adv = 1'b1; ins_valid = 1'b1; ins_rd = 5'd0; ins_data = 32'h55;
    tick();
    adv = 1'b0; ins_valid = 1'b0; #2;
    chk("x0 a.op0", bus_a.op_data[31:0], 32'h1234_5678);
    chk("x0 b.stall", {31'd0, bus_b.stall}, 32'd0);

    // Flush together with advance; x9 insertion is suppressed.
    adv = 1'b1; ins_valid = 1'b1; ins_rd = 5'd4; ins_data = 32'h44;
    tick();
    ins_rd = 5'd3; ins_data = 32'h33;
    tick();
    flush = 1'b1; ins_rd = 5'd9; ins_data = 32'h99;
    tick();
    flush = 1'b0; adv = 1'b0; ins_valid = 1'b0; rs0 = 5'd3; rs1 = 5'd9; #2;
    chk("flush x3", bus_a.op_data[31:0], 32'h1234_5678);
    chk("flush x9", bus_b.op_data[63:32], 32'hB1B1_1111);
    rs0 = 5'd4; #2;
    chk("flush x4 a", bus_a.op_data[31:0], 32'h44);
    chk("flush x4 b", bus_b.op_data[31:0], 32'h44);

    // Flush without advance kills entry 0 in place.
    adv = 1'b1; ins_valid = 1'b1; ins_rd = 5'd6; ins_data = 32'h66;
    tick();
    adv = 1'b0; ins_valid = 1'b0; rs0 = 5'd6; #2;
    chk("x6 live", bus_a.op_data[31:0], 32'h66);
    flush = 1'b1;
    tick();
    flush = 1'b0; #2;
    chk("x6 flushed", bus_b.op_data[31:0], 32'h1234_5678);

    // Asynchronous reset mid-run with three live entries.
    adv = 1'b1; ins_valid = 1'b1;
    ins_rd = 5'd1; ins_data = 32'h101; tick();
    ins_rd = 5'd2; ins_data = 32'h202; tick();
    ins_rd = 5'd3; ins_data = 32'h303; tick();
    adv = 1'b0; ins_valid = 1'b0; rs0 = 5'd1; rs1 = 5'd3; #2;
    chk("pre-rst op0", bus_a.op_data[31:0], 32'h101);
    chk("pre-rst op1", bus_b.op_data[63:32], 32'h303);
    #1 rst_n = 1'b0;
    #1;
    chk("arst a.op0", bus_a.op_data[31:0], 32'h1234_5678);
    chk("arst b.op1", bus_b.op_data[63:32], 32'hB1B1_1111);
    chk("arst b.cnt", bus_b.stall_cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
